alu_operand_loader: RTL and testbench



---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_operand_loader_button_debouncer.sv | 70 +++++++
 rtl/alu_operand_loader.sv | 102 ++++++++++
 tb/tb_alu_operand_loader.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU datapath definitions: default widths, opcodes and loaded-flag indices.
// Used by alu_operand_loader and the downstream ALU.
package alu_pkg;

   localparam int BUS_WIDTH_DEF = 8;
   localparam int OP_WIDTH_DEF  = 6;

   localparam logic [5:0] ADD = 6'h20;
   localparam logic [5:0] SUB = 6'h22;
   localparam logic [5:0] AND = 6'h24;
   localparam logic [5:0] OR  = 6'h25;
   localparam logic [5:0] XOR = 6'h26;
   localparam logic [5:0] SRA = 6'h03;
   localparam logic [5:0] SRL = 6'h02;
   localparam logic [5:0] NOR = 6'h27;

   // Loaded-flag bit positions; the clear button sits after them in the press vector.
   localparam int LD_A    = 0;
   localparam int LD_B    = 1;
   localparam int LD_OP   = 2;
   localparam int BTN_CLR = 3;

   typedef enum logic [1:0] {
      SEL_A   = 2'd0,
      SEL_B   = 2'd1,
      SEL_OP  = 2'd2,
      SEL_CLR = 2'd3
   } btn_sel_e;

   function automatic logic all_loaded(input logic [2:0] flags);
      return &flags;
   endfunction

endpackage

// File: rtl/alu_operand_loader_button_debouncer.sv
// Button conditioner: 2-FF synchroniser, optional debounce counter, rising-edge press pulse.
// Debounce counter exists only when LOADER_DEBOUNCE_EN is defined.
module button_debouncer #(
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_raw,
   output logic press
);

   logic meta_q;
   logic sync_q;
   logic deb;
   logic deb_prev_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta_q     <= 1'b0;
         sync_q     <= 1'b0;
         deb_prev_q <= 1'b0;
      end else begin
         meta_q     <= btn_raw;
         sync_q     <= meta_q;
         deb_prev_q <= deb;
      end
   end

`ifdef LOADER_DEBOUNCE_EN
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             deb_q, deb_d;

   // Counter restarts on any agreeing clock, so only an uninterrupted run flips deb.
   always_comb begin
      cnt_d = cnt_q;
      deb_d = deb_q;
      if (sync_q != deb_q) begin
         if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            deb_d = sync_q;
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end else begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
         deb_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         deb_q <= deb_d;
      end
   end

   assign deb = deb_q;
`else
   logic unused_cfg;
   assign unused_cfg = (DEBOUNCE_CYCLES > 0);
   assign deb        = sync_q;
`endif

   assign press = deb & ~deb_prev_q;

endmodule

// File: rtl/alu_operand_loader.sv
// Operand/opcode capture stage for the ALU: switch value is latched into A, B or Op on a button press.
// Button debouncing is enabled by defining LOADER_DEBOUNCE_EN.
module alu_operand_loader
   import alu_pkg::*;
#(
   parameter int BUS_WIDTH       = BUS_WIDTH_DEF,
   parameter int OP_WIDTH        = OP_WIDTH_DEF,
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [BUS_WIDTH-1:0] switches,
   input  logic                 btn_a,
   input  logic                 btn_b,
   input  logic                 btn_op,
   input  logic                 btn_clr,
   output logic [BUS_WIDTH-1:0] A,
   output logic [BUS_WIDTH-1:0] B,
   output logic [OP_WIDTH-1:0]  Op,
   output logic [2:0]           loaded,
   output logic                 valid,
   output logic                 update
);

   logic [BUS_WIDTH-1:0] sw_meta_q, sw_sync_q;
   logic [3:0]           btn_raw;
   logic [3:0]           press;

   logic [BUS_WIDTH-1:0] a_q, a_d;
   logic [BUS_WIDTH-1:0] b_q, b_d;
   logic [OP_WIDTH-1:0]  op_q, op_d;
   logic [2:0]           loaded_q, loaded_d;
   logic                 update_q, update_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sw_meta_q <= '0;
         sw_sync_q <= '0;
      end else begin
         sw_meta_q <= switches;
         sw_sync_q <= sw_meta_q;
      end
   end

   assign btn_raw = {btn_clr, btn_op, btn_b, btn_a};

   for (genvar i = 0; i < 4; i++) begin : g_btn
      button_debouncer #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_deb (
         .clk     (clk),
         .reset   (reset),
         .btn_raw (btn_raw[i]),
         .press   (press[i])
      );
   end

   // Clear is applied first so a coincident load still leaves its own flag set.
   always_comb begin
      a_d      = a_q;
      b_d      = b_q;
      op_d     = op_q;
      loaded_d = press[BTN_CLR] ? 3'b000 : loaded_q;
      if (press[LD_A]) begin
         a_d            = sw_sync_q;
         loaded_d[LD_A] = 1'b1;
      end
      if (press[LD_B]) begin
         b_d            = sw_sync_q;
         loaded_d[LD_B] = 1'b1;
      end
      if (press[LD_OP]) begin
         op_d            = sw_sync_q[OP_WIDTH-1:0];
         loaded_d[LD_OP] = 1'b1;
      end
      update_d = |press[LD_OP:LD_A];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= '0;
         loaded_q <= '0;
         update_q <= 1'b0;
      end else begin
         a_q      <= a_d;
         b_q      <= b_d;
         op_q     <= op_d;
         loaded_q <= loaded_d;
         update_q <= update_d;
      end
   end

   assign A      = a_q;
   assign B      = b_q;
   assign Op     = op_q;
   assign loaded = loaded_q;
   assign valid  = all_loaded(loaded_q);
   assign update = update_q;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Self-checking bench for alu_operand_loader: directed table, timing corner cases, random ops vs. model.
// Works with LOADER_DEBOUNCE_EN defined or undefined.
module tb_alu_operand_loader;
   import alu_pkg::*;

   localparam int DEB = 4;
`ifdef LOADER_DEBOUNCE_EN
   localparam int LAT = DEB + 3;
   localparam int MID = 4;
`else
   localparam int LAT = 3;
   localparam int MID = 2;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] switches = '0;
   logic       btn_a = 1'b0, btn_b = 1'b0, btn_op = 1'b0, btn_clr = 1'b0;
   logic [7:0] a_o, b_o;
   logic [5:0] op_o;
   logic [2:0] loaded_o;
   logic       valid_o, update_o;

   int checks = 0;
   int failures = 0;
   int upd_cnt = 0;

   alu_operand_loader #(
      .BUS_WIDTH(8), .OP_WIDTH(6), .DEBOUNCE_CYCLES(DEB)
   ) dut (
      .clk(clk), .reset(reset), .switches(switches),
      .btn_a(btn_a), .btn_b(btn_b), .btn_op(btn_op), .btn_clr(btn_clr),
      .A(a_o), .B(b_o), .Op(op_o), .loaded(loaded_o), .valid(valid_o), .update(update_o)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (update_o === 1'b1) upd_cnt++;

   typedef struct {
      logic [3:0] btns;   // {clr, op, b, a}
      logic [7:0] sw;
      logic [7:0] ea;
      logic [7:0] eb;
      logic [5:0] eop;
      logic [2:0] eld;
      logic       ev;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_btns(input logic [3:0] m);
      btn_a   = m[0];
      btn_b   = m[1];
      btn_op  = m[2];
      btn_clr = m[3];
   endtask

   task automatic chk_state(input string nm, input logic [7:0] ea, input logic [7:0] eb,
                            input logic [5:0] eop, input logic [2:0] eld);
      chk({nm, ".A"}, 32'(a_o), 32'(ea));
      chk({nm, ".B"}, 32'(b_o), 32'(eb));
      chk({nm, ".Op"}, 32'(op_o), 32'(eop));
      chk({nm, ".loaded"}, 32'(loaded_o), 32'(eld));
      chk({nm, ".valid"}, 32'(valid_o), 32'(eld == 3'b111));
   endtask

   // Behavioural model for the random phase.
   logic [7:0] m_a, m_b;
   logic [5:0] m_op;
   logic [2:0] m_ld;

   initial begin
      int base;
      int hold;
      int sel;
      logic [7:0] sw;

      vecs[0] = '{4'b0001, 8'h0F, 8'h0F, 8'h3C, 6'h00, 3'b011, 1'b0};
      vecs[1] = '{4'b0010, 8'hF0, 8'h0F, 8'hF0, 6'h00, 3'b011, 1'b0};
      vecs[2] = '{4'b0100, 8'h24, 8'h0F, 8'hF0, AND,   3'b111, 1'b1};
      vecs[3] = '{4'b1001, 8'h11, 8'h11, 8'hF0, AND,   3'b001, 1'b0};
      vecs[4] = '{4'b1000, 8'h00, 8'h11, 8'hF0, AND,   3'b000, 1'b0};
      vecs[5] = '{4'b0111, 8'h5A, 8'h5A, 8'h5A, 6'h1A, 3'b111, 1'b1};
      vecs[6] = '{4'b1010, 8'h99, 8'h5A, 8'h99, 6'h1A, 3'b010, 1'b0};

      #1;
      chk_state("reset", 8'h00, 8'h00, 6'h00, 3'b000);
      chk("reset.update", 32'(update_o), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;

      // Exact latency on A, single-cycle update pulse.
      switches = 8'hA5;
      base = upd_cnt;
      btn_a = 1'b1;
      step(LAT - 1);
      chk("lat.A_before", 32'(a_o), 32'h00);
      chk("lat.update_before", 32'(update_o), 32'd0);
      step(1);
      chk_state("lat", 8'hA5, 8'h00, 6'h00, 3'b001);
      chk("lat.update_high", 32'(update_o), 32'd1);
      step(1);
      chk("lat.update_low", 32'(update_o), 32'd0);
      btn_a = 1'b0;
      step(LAT + 2);
      chk("lat.update_count", 32'(upd_cnt - base), 32'd1);

`ifdef LOADER_DEBOUNCE_EN
      // Glitch shorter than the debounce window must be ignored.
      switches = 8'h77;
      base = upd_cnt;
      btn_b = 1'b1;
      step(DEB - 1);
      btn_b = 1'b0;
      step(LAT + 4);
      chk("glitch.update_count", 32'(upd_cnt - base), 32'd0);
      chk("glitch.B", 32'(b_o), 32'h00);
`endif
      switches = 8'h3C;
      btn_b = 1'b1;
      step(6);
      btn_b = 1'b0;
      step(LAT + 2);
      chk_state("hold6", 8'hA5, 8'h3C, 6'h00, 3'b011);

      for (int i = 0; i < 7; i++) begin
         base = upd_cnt;
         switches = vecs[i].sw;
         set_btns(vecs[i].btns);
         step(LAT);
         chk_state($sformatf("vec%0d", i), vecs[i].ea, vecs[i].eb, vecs[i].eop, vecs[i].eld);
         chk($sformatf("vec%0d.valid_tbl", i), 32'(valid_o), 32'(vecs[i].ev));
         chk($sformatf("vec%0d.update", i), 32'(update_o), 32'(|vecs[i].btns[2:0]));
         set_btns(4'b0000);
         step(LAT + 2);
         chk($sformatf("vec%0d.update_count", i), 32'(upd_cnt - base), 32'(|vecs[i].btns[2:0]));
      end

      // Reset in the middle of a debounce run, button still held afterwards.
      switches = 8'h2B;
      btn_op = 1'b1;
      step(MID);
      reset = 1'b1;
      #1;
      chk_state("midrst", 8'h00, 8'h00, 6'h00, 3'b000);
      chk("midrst.update", 32'(update_o), 32'd0);
      step(2);
      reset = 1'b0;
      step(LAT - 1);
      chk("midrst.Op_before", 32'(op_o), 32'h00);
      chk("midrst.update_before", 32'(update_o), 32'd0);
      step(1);
      chk_state("midrst_load", 8'h00, 8'h00, 6'h2B, 3'b100);
      chk("midrst.update_high", 32'(update_o), 32'd1);
      btn_op = 1'b0;
      step(LAT + 2);

      // Long hold gives one load only.
      switches = 8'h7E;
      base = upd_cnt;
      btn_a = 1'b1;
      step(20);
      chk("hold20.A", 32'(a_o), 32'h7E);
      btn_a = 1'b0;
      step(LAT + 2);
      chk("hold20.update_count", 32'(upd_cnt - base), 32'd1);

      m_a = 8'h7E; m_b = 8'h00; m_op = 6'h2B; m_ld = 3'b101;
      for (int n = 0; n < 30; n++) begin
         sel  = int'($urandom_range(0, 3));
         sw   = 8'($urandom);
         hold = LAT + int'($urandom_range(0, 4));
         base = upd_cnt;
         switches = sw;
         set_btns(4'(1 << sel));
         step(hold);
         set_btns(4'b0000);
         step(LAT + 2);
         case (sel)
            0: begin m_a = sw; m_ld[LD_A] = 1'b1; end
            1: begin m_b = sw; m_ld[LD_B] = 1'b1; end
            2: begin m_op = sw[5:0]; m_ld[LD_OP] = 1'b1; end
            default: m_ld = 3'b000;
         endcase
         chk_state($sformatf("rnd%0d", n), m_a, m_b, m_op, m_ld);
         chk($sformatf("rnd%0d.update_count", n), 32'(upd_cnt - base), 32'(sel != 3));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

endmodule
